// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the fabric clock divider/selector.
package clk_div_pkg;
  localparam int unsigned CLK_HZ          = 100_000_000;
  localparam logic [31:0] DEF_HALF_VEC    = 32'h0A_05_03_01;
  localparam int          DEF_LOCK_CYCLES = 16;
  localparam int          HV_MAX          = 512;

  typedef enum logic {RUN, PENDING} sw_state_e;

  // Extract the w-bit half-period field of channel i from a packed vector.
  function automatic logic [31:0] half_of(input logic [HV_MAX-1:0] vec,
                                          input int i, input int w);
    logic [HV_MAX-1:0] s;
    logic [31:0]       mask;
    s    = vec >> (w * i);
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return s[31:0] & mask;
  endfunction
endpackage

// File: rtl/clk_div_select_sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs such as switches.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/clk_div_select.sv
// Selectable fabric clock divider with lock delay and glitch-free channel switching.
module clk_div_select
  import clk_div_pkg::*;
#(
  parameter int                   NCH         = 4,
  parameter int                   CNT_W       = 8,
  parameter logic [NCH*CNT_W-1:0] HALF_VEC    = DEF_HALF_VEC,
  parameter int                   LOCK_CYCLES = DEF_LOCK_CYCLES,
  localparam int                  SEL_W       = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  output logic             div_clk,
  output logic             div_tick,
  output logic             locked,
  output logic [SEL_W-1:0] active_sel,
  output logic             switching,
  output logic             sel_err
);
  localparam int LCW   = $clog2(LOCK_CYCLES) + 1;
  localparam int NSLOT = 1 << SEL_W;

  // Unused selector codes map to 1 so the table is always fully populated.
  logic [CNT_W-1:0] half_tab [NSLOT];
  for (genvar i = 0; i < NSLOT; i++) begin : g_half
    if (i < NCH) begin : g_ch
      localparam logic [31:0] HRAW = half_of(HV_MAX'(HALF_VEC), i, CNT_W);
      assign half_tab[i] = (HRAW == 0) ? CNT_W'(1) : HRAW[CNT_W-1:0];
    end else begin : g_pad
      assign half_tab[i] = CNT_W'(1);
    end
  end

  logic [SEL_W-1:0] sel_s;
  sync_2ff #(.W(SEL_W)) u_sync (.clk(clk), .rst(rst), .d(sel), .q(sel_s));

  logic [LCW-1:0]   lock_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h;
  logic             sel_ok, pending, term, swap;
  sw_state_e        state;

  assign sel_ok    = ({1'b0, sel_s} < (SEL_W+1)'(NCH));
  assign pending   = sel_ok && (sel_s != active_sel);
  assign h         = half_tab[active_sel];
  assign term      = (cnt == h - 1'b1);
  // Only swap at the end of a high phase so the new channel opens with a full low phase.
  assign swap      = locked && term && div_clk && pending;
  assign switching = (state == PENDING);

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt   <= '0;
      locked     <= 1'b0;
      cnt        <= '0;
      div_clk    <= 1'b0;
      div_tick   <= 1'b0;
      active_sel <= '0;
      state      <= RUN;
      sel_err    <= 1'b0;
    end else begin
      sel_err  <= !sel_ok;
      state    <= (pending && !swap) ? PENDING : RUN;
      div_tick <= 1'b0;
      if (!locked) begin
        cnt     <= '0;
        div_clk <= 1'b0;
        if (lock_cnt == LCW'(LOCK_CYCLES - 1)) locked <= 1'b1;
        else                                   lock_cnt <= lock_cnt + 1'b1;
      end else if (term) begin
        cnt      <= '0;
        div_clk  <= !div_clk;
        div_tick <= !div_clk;
        if (swap) active_sel <= sel_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clk_div_select.sv
// Self-checking bench: time-based behavioural model plus directed literal checks.
module tb_clk_div_select;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [1:0] sel3 = 2'd1;

  logic       div_clk, div_tick, locked, switching, sel_err;
  logic [1:0] active_sel;
  logic       d3_clk, d3_tick, d3_locked, d3_sw, d3_err;
  logic [1:0] d3_act;

  always #5 clk = ~clk;

  clk_div_select u_dut (
    .clk(clk), .rst(rst), .sel(sel), .div_clk(div_clk), .div_tick(div_tick),
    .locked(locked), .active_sel(active_sel), .switching(switching), .sel_err(sel_err)
  );

  clk_div_select #(.NCH(3), .CNT_W(8), .HALF_VEC(24'h05_03_01), .LOCK_CYCLES(16)) u_dut3 (
    .clk(clk), .rst(rst), .sel(sel3), .div_clk(d3_clk), .div_tick(d3_tick),
    .locked(d3_locked), .active_sel(d3_act), .switching(d3_sw), .sel_err(d3_err)
  );

  localparam int LOCK = 16;
  localparam int HALF [4] = '{1, 3, 5, 10};

  int checks = 0;
  int errors = 0;

  // Model state: time since reset release, channel, and the phase at which it started.
  int         since, ch, p0;
  bit         chk_en = 1'b0;
  bit         m_lock, m_clk, m_tick, m_sw, m_err;
  logic [1:0] m_s1, m_s2;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int d, h;
    logic [1:0] ssp;
    if (rst) begin
      since = 0; ch = 0; p0 = 0; m_s1 = 0; m_s2 = 0;
      m_lock = 0; m_clk = 0; m_tick = 0; m_sw = 0; m_err = 0;
      chk_en = 1'b1;
    end else begin
      ssp = m_s2;
      since++;
      m_lock = (since >= LOCK);
      if (m_lock) begin
        d = since - LOCK - p0;
        h = HALF[ch];
        if (d > 0 && d % (2*h) == 0 && int'(ssp) != ch) begin
          ch = int'(ssp); p0 = since - LOCK; d = 0; h = HALF[ch];
        end
        m_clk  = ((d / h) % 2) == 1;
        m_tick = (d > 0) && (d % (2*h) == h);
      end else begin
        m_clk = 0; m_tick = 0;
      end
      m_sw  = (int'(ssp) != ch);
      m_err = (int'(ssp) >= 4);
      m_s2 = m_s1;
      m_s1 = sel;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (chk_en) begin
      check("div_clk", div_clk, m_clk);
      check("div_tick", div_tick, m_tick);
      check("locked", locked, m_lock);
      check("active_sel", active_sel, ch);
      check("switching", switching, m_sw);
      check("sel_err", sel_err, m_err);
    end
  endtask

  task automatic measure(output int hi, output int lo, output int per);
    int n;
    n = 0; while (div_clk && n < 100) begin step(); n++; end
    n = 0; while (!div_clk && n < 100) begin step(); n++; end
    hi = 0; do begin step(); hi++; end while (div_clk && hi < 100);
    lo = 0; do begin step(); lo++; end while (!div_clk && lo < 100);
    per = 0; do begin step(); per++; end while (!div_tick && per < 100);
  endtask

  initial begin
    int n, hi, lo, per;
    repeat (3) step();
    check("rst_div_clk", div_clk, 0);
    check("rst_div_tick", div_tick, 0);
    check("rst_locked", locked, 0);
    check("rst_active_sel", active_sel, 0);
    check("rst_switching", switching, 0);
    check("rst_sel_err", sel_err, 0);
    rst = 1'b0;

    n = 0; do begin step(); n++; end while (!locked && n < 100);
    check("lock_latency", n, 16);
    n = 0; do begin step(); n++; end while (!div_clk && n < 100);
    check("first_rise", n, 1);

    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      n = 0; while (int'(active_sel) != k && n < 200) begin step(); n++; end
      check("sel_reached", active_sel, k);
      repeat (6 * HALF[k]) step();
      measure(hi, lo, per);
      check("high_len", hi, HALF[k]);
      check("low_len", lo, HALF[k]);
      check("tick_period", per, 2 * HALF[k]);
    end

    // Switch 3 -> 1 in the middle of a ch3 high phase.
    n = 0; while (div_clk && n < 50) begin step(); n++; end
    n = 0; while (!div_clk && n < 50) begin step(); n++; end
    repeat (2) step();
    sel = 2'd1;
    n = 0; do begin step(); n++; end while (!switching && n < 50);
    check("switch_latency", n, 3);
    check("no_early_swap", active_sel, 3);
    n = 0; while (div_clk && n < 50) begin step(); n++; end
    check("swap_at_fall", active_sel, 1);
    lo = 0; do begin step(); lo++; end while (!div_clk && lo < 50);
    hi = 0; do begin step(); hi++; end while (div_clk && hi < 50);
    check("new_low_len", lo, 3);
    check("new_high_len", hi, 3);

    // Request 2 then revert to 3 before the boundary.
    sel = 2'd3;
    n = 0; while (active_sel != 2'd3 && n < 100) begin step(); n++; end
    n = 0; while (!div_clk && n < 50) begin step(); n++; end
    n = 0; while (div_clk && n < 50) begin step(); n++; end
    sel = 2'd2;
    repeat (4) step();
    check("revert_pending", switching, 1);
    sel = 2'd3;
    repeat (4) step();
    check("revert_cleared", switching, 0);
    n = 0; while (!div_clk && n < 50) begin step(); n++; end
    n = 0; while (div_clk && n < 50) begin step(); n++; end
    check("revert_no_swap", active_sel, 3);

    // Reset mid-run on ch2.
    sel = 2'd2;
    n = 0; while (active_sel != 2'd2 && n < 100) begin step(); n++; end
    repeat (7) step();
    rst = 1'b1;
    step();
    check("midrst_div_clk", div_clk, 0);
    check("midrst_locked", locked, 0);
    check("midrst_active", active_sel, 0);
    rst = 1'b0;
    n = 0; do begin step(); n++; end while (!locked && n < 100);
    check("relock_latency", n, 16);
    n = 0; while (active_sel != 2'd2 && n < 50) begin step(); n++; end
    check("relock_swap_delay", n, 2);

    // NCH=3 build: code 3 is invalid and ignored.
    repeat (10) step();
    check("nch3_active", d3_act, 1);
    sel3 = 2'd3;
    repeat (4) step();
    check("nch3_err", d3_err, 1);
    check("nch3_keep", d3_act, 1);
    check("nch3_nosw", d3_sw, 0);
    sel3 = 2'd2;
    repeat (4) step();
    check("nch3_err_clr", d3_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
